// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell store: default maze geometry,
// cell values and the store state encoding.
package maze_pkg;

  localparam int MAZE_WIDTH  = 30;
  localparam int MAZE_HEIGHT = 40;
  localparam int MAZE_CELLS  = MAZE_WIDTH * MAZE_HEIGHT;
  localparam int MAZE_ADDR_W = 11;

  localparam logic WALL  = 1'b1;
  localparam logic FLOOR = 1'b0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } maze_state_t;

endpackage

// File: rtl/maze_cell_ram.sv
// One-bit-wide RAM with one write port and one registered read port.
// Reads return the contents from before a same-cycle write; any
// write-first behaviour is handled by the caller.
module maze_cell_ram
  import maze_pkg::*;
#(
  parameter int DEPTH  = MAZE_CELLS,
  parameter int ADDR_W = MAZE_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_bit,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bit
);

  logic mem [DEPTH];

  // Write port and one-cycle registered read port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_bit;
    end
    rd_bit <= mem[rd_addr];
  end

endmodule

// File: rtl/maze_cell_store.sv
// Maze cell store: one bit per cell, self-clearing to CLEAR_VALUE,
// generator write port and a fixed two-cycle read port with
// write-first bypass for same-cycle collisions.
module maze_cell_store
  import maze_pkg::*;
#(
  parameter int   WIDTH       = MAZE_WIDTH,
  parameter int   HEIGHT      = MAZE_HEIGHT,
  parameter int   ADDR_W      = MAZE_ADDR_W,
  parameter logic CLEAR_VALUE = WALL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_data,
  input  logic              wr_done,
  output logic              content_valid,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              rd_data,
  output logic              rd_data_valid,
  output logic              addr_error
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(CELLS);
  endfunction

  maze_state_t       state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              wr_fire;
  logic              wr_in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_wbit;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_q;

  logic              rd_force_p0;
  logic              rd_byp_p0;
  logic              vld_p1;
  logic              rd_force_p1;
  logic              rd_byp_p1;
  logic              rd_byp_bit_p1;

  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = in_range(wr_address);

  // Clear sequencer owns the write port in CLEAR, the generator in SERVE.
  assign ram_we    = (state == ST_CLEAR) || (wr_fire && wr_in_range);
  assign ram_waddr = (state == ST_CLEAR) ? clr_cnt : wr_address;
  assign ram_wbit  = (state == ST_CLEAR) ? CLEAR_VALUE : wr_data;

  // Stage p0: classify the incoming read request.
  assign rd_force_p0 = (state == ST_CLEAR) || !in_range(rd_address);
  assign rd_byp_p0   = wr_fire && wr_in_range && (wr_address == rd_address);
  assign ram_raddr   = in_range(rd_address) ? rd_address : '0;

  maze_cell_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_bit  (ram_wbit),
    .rd_addr (ram_raddr),
    .rd_bit  (ram_q)
  );

  // Clear/serve state machine with registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_CLEAR;
      clr_cnt       <= '0;
      clear_busy    <= 1'b1;
      wr_ready      <= 1'b0;
      content_valid <= 1'b0;
      addr_error    <= 1'b0;
    end else begin
      if (wr_fire && !wr_in_range) begin
        addr_error <= 1'b1;
      end
      case (state)
        ST_CLEAR: begin
          if (clear_start) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_CELL) begin
            state      <= ST_SERVE;
            clear_busy <= 1'b0;
            wr_ready   <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_SERVE: begin
          if (clear_start) begin
            state         <= ST_CLEAR;
            clr_cnt       <= '0;
            clear_busy    <= 1'b1;
            wr_ready      <= 1'b0;
            content_valid <= 1'b0;
          end else if (wr_done) begin
            content_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage p1/p2 valid pipeline; reset drops any in-flight reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      vld_p1        <= rd_valid;
      rd_data_valid <= vld_p1;
    end
  end

  // Stage p1: capture read selection alongside the RAM access.
  always_ff @(posedge clock) begin
    rd_force_p1   <= rd_force_p0;
    rd_byp_p1     <= rd_byp_p0;
    rd_byp_bit_p1 <= wr_data;
  end

  // Stage p2: pick forced value, bypassed write or RAM contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= CLEAR_VALUE;
    end else if (vld_p1) begin
      if (rd_force_p1) begin
        rd_data <= CLEAR_VALUE;
      end else if (rd_byp_p1) begin
        rd_data <= rd_byp_bit_p1;
      end else begin
        rd_data <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_maze_cell_store.sv
// Directed bench for maze_cell_store at default geometry (30 x 40).
module tb_maze_cell_store;
  import maze_pkg::*;

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic        clear_start = 1'b0;
  logic        wr_valid    = 1'b0;
  logic [10:0] wr_address  = '0;
  logic        wr_data     = 1'b0;
  logic        wr_done     = 1'b0;
  logic        rd_valid    = 1'b0;
  logic [10:0] rd_address  = '0;
  logic        clear_busy;
  logic        wr_ready;
  logic        content_valid;
  logic        rd_data;
  logic        rd_data_valid;
  logic        addr_error;

  int checks = 0;
  int errors = 0;
  int n;

  maze_cell_store #(
    .WIDTH       (30),
    .HEIGHT      (40),
    .ADDR_W      (11),
    .CLEAR_VALUE (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .wr_done       (wr_done),
    .content_valid (content_valid),
    .rd_valid      (rd_valid),
    .rd_address    (rd_address),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .addr_error    (addr_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic b);
    wr_valid   = 1'b1;
    wr_address = 11'(a);
    wr_data    = b;
    step();
    wr_valid   = 1'b0;
  endtask

  // Single read: no valid at +1, valid pulse with data at +2, gone at +3.
  task automatic rd(input int a, input logic exp, input string tag);
    rd_valid   = 1'b1;
    rd_address = 11'(a);
    step();
    rd_valid   = 1'b0;
    check1({tag, "_vld_early"}, rd_data_valid, 1'b0);
    step();
    check1({tag, "_vld"}, rd_data_valid, 1'b1);
    check1(tag, rd_data, exp);
    step();
    check1({tag, "_vld_late"}, rd_data_valid, 1'b0);
  endtask

  // Count cycles with clear_busy high, bounded.
  task automatic count_busy();
    while (clear_busy === 1'b1 && n < 2000) begin
      n++;
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    check1("rst_clear_busy", clear_busy, 1'b1);
    check1("rst_wr_ready", wr_ready, 1'b0);
    check1("rst_content_valid", content_valid, 1'b0);
    check1("rst_rd_data", rd_data, 1'b1);
    check1("rst_rd_data_valid", rd_data_valid, 1'b0);
    check1("rst_addr_error", addr_error, 1'b0);

    reset = 1'b0;
    n = 0;
    count_busy();
    checkn("clear_len_reset", n, 1200);
    check1("serve_wr_ready", wr_ready, 1'b1);
    check1("serve_content_valid", content_valid, 1'b0);
    rd(0, 1'b1, "rd_0");
    rd(1199, 1'b1, "rd_1199");

    // Write a floor cell, then back-to-back reads of it and its neighbour.
    wr(31, FLOOR);
    rd_valid   = 1'b1;
    rd_address = 11'd31;
    step();
    rd_address = 11'd32;
    step();
    rd_valid   = 1'b0;
    check1("b2b_31_vld", rd_data_valid, 1'b1);
    check1("b2b_31", rd_data, 1'b0);
    step();
    check1("b2b_32_vld", rd_data_valid, 1'b1);
    check1("b2b_32", rd_data, 1'b1);
    step();
    check1("b2b_end_vld", rd_data_valid, 1'b0);

    // Same-cycle write and read of cell 5: new value must come back.
    wr_valid   = 1'b1;
    wr_address = 11'd5;
    wr_data    = FLOOR;
    rd_valid   = 1'b1;
    rd_address = 11'd5;
    step();
    wr_valid   = 1'b0;
    rd_valid   = 1'b0;
    step();
    check1("coll_vld", rd_data_valid, 1'b1);
    check1("coll_data", rd_data, 1'b0);
    step();
    rd(5, 1'b0, "rd_5_after");

    // Out-of-range write.
    check1("oor_pre_err", addr_error, 1'b0);
    wr(1500, FLOOR);
    check1("oor_err", addr_error, 1'b1);
    repeat (5) step();
    check1("oor_err_held", addr_error, 1'b1);
    rd(1500, 1'b1, "rd_1500");
    rd(476, 1'b1, "rd_476_alias");

    // content_valid set by wr_done and held after it falls.
    wr_done = 1'b1;
    step();
    check1("cv_set", content_valid, 1'b1);
    wr_done = 1'b0;
    step();
    check1("cv_held", content_valid, 1'b1);

    // clear_start with a same-cycle write to cell 1199.
    clear_start = 1'b1;
    wr_valid    = 1'b1;
    wr_address  = 11'd1199;
    wr_data     = FLOOR;
    check1("cs_wr_ready", wr_ready, 1'b1);
    step();
    clear_start = 1'b0;
    wr_valid    = 1'b0;
    check1("cs_cv_cleared", content_valid, 1'b0);
    check1("cs_busy", clear_busy, 1'b1);
    check1("cs_wr_ready_low", wr_ready, 1'b0);
    rd(1199, 1'b1, "rd_1199_in_clear");
    n = 3;
    count_busy();
    checkn("clear_len_start", n, 1200);
    rd(31, 1'b1, "rd_31_cleared");
    rd(1199, 1'b1, "rd_1199_cleared");
    rd(5, 1'b1, "rd_5_cleared");

    // clear_start during CLEAR restarts the counter.
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (99) step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n = 0;
    count_busy();
    checkn("clear_len_restart", n, 1200);

    // Reset with two reads in flight.
    wr(7, FLOOR);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    wr(1600, WALL);
    rd(7, 1'b0, "rd_7_pre_reset");
    check1("pre_rst_cv", content_valid, 1'b1);
    check1("pre_rst_err", addr_error, 1'b1);
    rd_valid   = 1'b1;
    rd_address = 11'd7;
    step();
    rd_address = 11'd8;
    reset      = 1'b1;
    step();
    rd_valid   = 1'b0;
    reset      = 1'b0;
    check1("mid_rst_vld0", rd_data_valid, 1'b0);
    check1("mid_rst_busy", clear_busy, 1'b1);
    check1("mid_rst_wr_ready", wr_ready, 1'b0);
    check1("mid_rst_cv", content_valid, 1'b0);
    check1("mid_rst_err", addr_error, 1'b0);
    check1("mid_rst_rd_data", rd_data, 1'b1);
    n = 0;
    step();
    n = 1;
    check1("mid_rst_vld1", rd_data_valid, 1'b0);
    count_busy();
    checkn("clear_len_mid_reset", n, 1200);
    rd(7, 1'b1, "rd_7_post_reset");
    rd(0, 1'b1, "rd_0_post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_cell_store.md
Name: maze_cell_store

Overview:
- Responder for the maze-cell read interface that the renderer drives with maze_address/maze_address_data.
- Also accepts cell writes from the maze generator.
- Holds one bit per cell (1 = wall, 0 = floor) for a WIDTH x HEIGHT maze.
- Fills itself with walls on reset or on request, and answers reads at a fixed latency so the renderer can pipeline its requests.

Parameters:
- WIDTH, 30, maze width in cells.
- HEIGHT, 40, maze height in cells.
- ADDR_W, 11, cell address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- CLEAR_VALUE, 1'b1, value written to every cell during clear (wall).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- clear_start  in  1  single-cycle pulse: refill all cells with CLEAR_VALUE.
- clear_busy  out  1  high while the clear sequence runs.
- wr_valid  in  1  generator write request.
- wr_ready  out  1  store can accept a write this cycle.
- wr_address  in  ADDR_W  cell index = x + WIDTH*y.
- wr_data  in  1  cell value.
- wr_done  in  1  generator finished (gen_end level).
- content_valid  out  1  maze complete and readable.
- rd_valid  in  1  read request.
- rd_address  in  ADDR_W  cell index to read.
- rd_data  out  1  cell value.
- rd_data_valid  out  1  rd_data corresponds to the request issued 2 cycles earlier.
- addr_error  out  1  sticky: an out-of-range write was seen.

Behaviour:
- States: CLEAR and SERVE. Reset forces CLEAR with clear counter = 0.
- Reset values: clear_busy=1, wr_ready=0, content_valid=0, rd_data=CLEAR_VALUE, rd_data_valid=0, addr_error=0.
- CLEAR:
  - Writes CLEAR_VALUE to cell[counter] each cycle; counter increments 0..WIDTH*HEIGHT-1.
  - After the last cell, moves to SERVE on the next cycle. Clear takes WIDTH*HEIGHT cycles (1200 at defaults). clear_busy drops the cycle SERVE is entered.
- SERVE:
  - wr_ready=1; a write completes when wr_valid && wr_ready.
  - clear_start moves back to CLEAR, resets the counter to 0 and clears content_valid.
- Writes during CLEAR: wr_ready=0, so the generator must hold wr_valid until accepted.
- Reads are accepted every cycle in both states (no backpressure).
  - Fixed latency: request at cycle N gives rd_data/rd_data_valid at N+2. rd_data_valid is a one-cycle pulse per request; back-to-back requests give back-to-back results.
  - A read issued during CLEAR returns CLEAR_VALUE.
- Read/write collision (same address, same cycle, write accepted): the read returns the newly written value (write-first bypass).
- Out-of-range address (>= WIDTH*HEIGHT):
  - Write is accepted, memory is unchanged, addr_error is set. addr_error clears only on reset.
  - Read returns CLEAR_VALUE with normal latency.
- content_valid:
  - Set on the first cycle in SERVE with wr_done=1.
  - Cleared by clear_start or reset. It stays set if wr_done later falls.
- clear_start during CLEAR restarts the counter at 0.
- clear_start and wr_valid in the same SERVE cycle: the write is accepted, then CLEAR begins next cycle and overwrites it.
- Reset mid-operation aborts everything. In-flight read results are discarded: rd_data_valid=0 for the next 2 cycles.
- Storage: single-port-write / single-port-read inferred RAM of WIDTH*HEIGHT bits. The clear writer and the generator writer are muxed onto the write port by state.

Decomposition:
- Shared package maze_pkg holds:
  - MAZE_WIDTH=30, MAZE_HEIGHT=40, MAZE_CELLS, MAZE_ADDR_W=11.
  - WALL=1'b1, FLOOR=1'b0.
  - state encoding ST_CLEAR, ST_SERVE.
- One sub-module, maze_cell_ram: plain registered-read bit RAM (one write port, one read port, one-cycle read). The bypass, latency alignment and state machine stay in maze_cell_store.

Test Plan:
- Reset then idle: clear_busy=1 for exactly 1200 cycles, then 0, wr_ready=1. Reading address 0 and 1199 returns 1 at +2 cycles with a rd_data_valid pulse.
- Write 0 to address 31, then read 31 and 32 back-to-back: rd_data 0 then 1 on consecutive cycles, each 2 cycles after its request.
- Same-cycle write address 5 = 0 and read address 5: rd_data=0 two cycles later.
- Write to address 1500: memory unchanged, addr_error=1 and held. Read 1500 returns 1.
- Assert wr_done in SERVE: content_valid=1 next cycle. Pulse clear_start: content_valid=0, clear_busy=1 for 1200 cycles, address 31 reads 1 afterwards.
- Assert reset with 2 reads in flight: no rd_data_valid for 2 cycles, outputs at reset values, clear restarts at address 0.
